// File: rtl/mips_core_pkg.sv
// Shared core types for checkpoint storage and hazard control.
// Holds default geometry, the checkpoint ID and register-file types.
package mips_core_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_NUM_REGS      = 32;
  localparam int DEF_DEPTH         = 4;
  localparam int DEF_CAPTURE_DELAY = 1;
  localparam int DEF_ID_W          = $clog2(DEF_DEPTH);

  typedef logic [DEF_ID_W-1:0] ckpt_id_t;

  typedef logic [DEF_NUM_REGS-1:0][DEF_DATA_WIDTH-1:0] reg_file_t;

endpackage

// File: rtl/register_checkpoint_buffer_ring_ctrl.sv
// Checkpoint ring controller: head/tail/count, live check, arbitration
// of take/release/restore, and the capture pipe for delayed sampling.
// Ports: i_clk/i_rst; i_take_req, i_release_req, i_restore_req/id in;
//   o_take_ready/done/id, o_restore_valid/err, o_count/full/empty out;
//   o_wr_en/o_wr_id slot write, o_rd_fire/o_rd_fwd restore control.
module checkpoint_ring_ctrl
  import mips_core_pkg::*;
#(
  parameter int DEPTH         = DEF_DEPTH,
  parameter int CAPTURE_DELAY = DEF_CAPTURE_DELAY,
  localparam int ID_W         = $clog2(DEPTH),
  localparam int CW           = ID_W + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_take_req,
  input  logic            i_release_req,
  input  logic            i_restore_req,
  input  logic [ID_W-1:0] i_restore_id,
  output logic            o_take_ready,
  output logic            o_take_done,
  output logic [ID_W-1:0] o_take_id,
  output logic            o_restore_valid,
  output logic            o_restore_err,
  output logic [CW-1:0]   o_count,
  output logic            o_full,
  output logic            o_empty,
  output logic            o_wr_en,
  output logic [ID_W-1:0] o_wr_id,
  output logic            o_rd_fire,
  output logic            o_rd_fwd
);

  logic [ID_W-1:0] r_head;
  logic [ID_W-1:0] r_tail;
  logic [CW-1:0]   r_count;
  logic            r_full;
  logic            r_empty;
  logic            r_pend_v;
  logic [ID_W-1:0] r_pend_id;
  logic            r_done_v;
  logic [ID_W-1:0] r_done_id;
  logic            r_rv;
  logic            r_err;

  logic [ID_W-1:0] w_rs_off;
  logic [ID_W-1:0] w_pend_off;
  logic            w_rs_live;
  logic            w_rs_ok;
  logic            w_rs_bad;
  logic            w_take_ready;
  logic            w_take;
  logic            w_rel;
  logic            w_cancel;
  logic            w_wr_en;
  logic [ID_W-1:0] w_wr_id;
  logic [ID_W-1:0] w_head_n;
  logic [ID_W-1:0] w_tail_n;
  logic [CW-1:0]   w_cnt_n;

  // Age of an ID relative to the oldest live slot.
  assign w_rs_off   = i_restore_id - r_head;
  assign w_pend_off = r_pend_id - r_head;
  assign w_rs_live  = {1'b0, w_rs_off} < r_count;

  assign w_rs_ok  = i_restore_req & w_rs_live;
  assign w_rs_bad = i_restore_req & ~w_rs_live;

  assign w_take_ready = ~r_full & ~i_restore_req;
  assign w_take       = i_take_req & w_take_ready;

  // A valid restore always leaves at least one live slot to release.
  assign w_rel = i_release_req & (w_rs_ok | ~r_empty);

  // Pending capture of a slot younger than the restore target dies.
  assign w_cancel = w_rs_ok & r_pend_v & (w_pend_off > w_rs_off);

  always_comb begin
    w_wr_en = 1'b0;
    w_wr_id = r_tail;
    if (CAPTURE_DELAY == 0) begin
      w_wr_en = w_take;
      w_wr_id = r_tail;
    end else begin
      w_wr_en = r_pend_v & ~w_cancel;
      w_wr_id = r_pend_id;
    end
  end

  always_comb begin
    w_head_n = r_head;
    w_tail_n = r_tail;
    w_cnt_n  = r_count;
    if (w_rs_ok) begin
      w_tail_n = i_restore_id + ID_W'(1);
      w_cnt_n  = {1'b0, w_rs_off} + CW'(1);
    end else if (w_take) begin
      w_tail_n = r_tail + ID_W'(1);
      w_cnt_n  = r_count + CW'(1);
    end
    if (w_rel) begin
      w_head_n = r_head + ID_W'(1);
      w_cnt_n  = w_cnt_n - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_pend_v  <= 1'b0;
      r_pend_id <= '0;
      r_done_v  <= 1'b0;
      r_done_id <= '0;
      r_rv      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_head    <= w_head_n;
      r_tail    <= w_tail_n;
      r_count   <= w_cnt_n;
      r_full    <= w_cnt_n == CW'(DEPTH);
      r_empty   <= w_cnt_n == '0;
      r_pend_v  <= (CAPTURE_DELAY != 0) & w_take;
      r_pend_id <= r_tail;
      r_done_v  <= w_wr_en;
      r_done_id <= w_wr_id;
      r_rv      <= w_rs_ok;
      r_err     <= w_rs_bad;
    end
  end

  assign o_take_ready    = w_take_ready;
  assign o_take_done     = r_done_v;
  // An accepting cycle reports the new ID; otherwise the completed one.
  assign o_take_id       = w_take ? r_tail : r_done_id;
  assign o_restore_valid = r_rv;
  assign o_restore_err   = r_err;
  assign o_count         = r_count;
  assign o_full          = r_full;
  assign o_empty         = r_empty;
  assign o_wr_en         = w_wr_en & ~i_rst;
  assign o_wr_id         = w_wr_id;
  assign o_rd_fire       = w_rs_ok;
  // Target still awaiting its sample: take the live value instead.
  assign o_rd_fwd        = (CAPTURE_DELAY != 0) & r_pend_v
                         & (r_pend_id == i_restore_id);

endmodule

// File: rtl/register_checkpoint_buffer.sv
// Ring of register-file checkpoints for speculative-path recovery.
// Ports: i_clk/i_rst, i_regs_in, take/release/restore handshakes,
//   o_regs_out restored image, o_count/o_full/o_empty occupancy.
module register_checkpoint_buffer
  import mips_core_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int CAPTURE_DELAY = DEF_CAPTURE_DELAY,
  localparam int ID_W         = $clog2(DEPTH)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] i_regs_in,
  input  logic                                i_take_req,
  output logic                                o_take_ready,
  output logic                                o_take_done,
  output logic [ID_W-1:0]                     o_take_id,
  input  logic                                i_release_req,
  input  logic                                i_restore_req,
  input  logic [ID_W-1:0]                     i_restore_id,
  output logic                                o_restore_valid,
  output logic                                o_restore_err,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] o_regs_out,
  output logic [ID_W:0]                       o_count,
  output logic                                o_full,
  output logic                                o_empty
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_slots [DEPTH];
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs_out;

  logic            w_wr_en;
  logic [ID_W-1:0] w_wr_id;
  logic            w_rd_fire;
  logic            w_rd_fwd;

  checkpoint_ring_ctrl #(
    .DEPTH         (DEPTH),
    .CAPTURE_DELAY (CAPTURE_DELAY)
  ) u_ctrl (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_take_req      (i_take_req),
    .i_release_req   (i_release_req),
    .i_restore_req   (i_restore_req),
    .i_restore_id    (i_restore_id),
    .o_take_ready    (o_take_ready),
    .o_take_done     (o_take_done),
    .o_take_id       (o_take_id),
    .o_restore_valid (o_restore_valid),
    .o_restore_err   (o_restore_err),
    .o_count         (o_count),
    .o_full          (o_full),
    .o_empty         (o_empty),
    .o_wr_en         (w_wr_en),
    .o_wr_id         (w_wr_id),
    .o_rd_fire       (w_rd_fire),
    .o_rd_fwd        (w_rd_fwd)
  );

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_slots[w_wr_id] <= i_regs_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regs_out <= '0;
    end else if (w_rd_fire) begin
      r_regs_out <= w_rd_fwd ? i_regs_in : r_slots[i_restore_id];
    end
  end

  assign o_regs_out = r_regs_out;

endmodule

// File: tb/tb_register_checkpoint_buffer.sv
// Directed bench for register_checkpoint_buffer (DEPTH 4, delay 1).
// Table of per-cycle vectors plus hand sequences for corner cases.
module tb_register_checkpoint_buffer;
  import mips_core_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      tk, rl, rs;
  logic [1:0] rid;
  reg_file_t rin;

  logic      take_ready, take_done, restore_valid, restore_err;
  logic [1:0] take_id;
  reg_file_t rout;
  logic [2:0] count;
  logic      full, empty;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  register_checkpoint_buffer dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_regs_in       (rin),
    .i_take_req      (tk),
    .o_take_ready    (take_ready),
    .o_take_done     (take_done),
    .o_take_id       (take_id),
    .i_release_req   (rl),
    .i_restore_req   (rs),
    .i_restore_id    (rid),
    .o_restore_valid (restore_valid),
    .o_restore_err   (restore_err),
    .o_regs_out      (rout),
    .o_count         (count),
    .o_full          (full),
    .o_empty         (empty)
  );

  typedef struct {
    bit         tk, rl, rs;
    bit [1:0]   rid;
    bit [7:0]   v;
    bit         rdy;
    bit [1:0]   id;
    bit         dn, rv, er;
    int         cnt;
    logic [31:0] r5;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(bit t, bit l, bit s, bit [1:0] d,
                              bit [7:0] v, bit rdy, bit [1:0] id,
                              bit dn, bit rv, bit er, int cnt,
                              logic [31:0] r5);
    vec_t x;
    x.tk = t; x.rl = l; x.rs = s; x.rid = d; x.v = v;
    x.rdy = rdy; x.id = id; x.dn = dn; x.rv = rv; x.er = er;
    x.cnt = cnt; x.r5 = r5;
    return x;
  endfunction

  function automatic reg_file_t fill(logic [31:0] base);
    reg_file_t r;
    for (int k = 0; k < 32; k++) r[k] = base | (32'(k) << 16);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_rf(string nm, reg_file_t act, reg_file_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got r5=%0h r0=%0h want r5=%0h r0=%0h",
                  nm, act[5], act[0], exp[5], exp[0]);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    tk = 0; rl = 0; rs = 0; rid = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    edge1();
    rst = 0;
  endtask

  reg_file_t P, Q, R, Z;

  initial begin
    P = fill(32'hC000_0001);
    Q = fill(32'hD000_0002);
    R = fill(32'hE000_0003);
    Z = '0;
    rin = '0;
    do_reset();

    chk("rst count", 32'(count), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst done", 32'(take_done), 0);
    chk("rst rv", 32'(restore_valid), 0);
    chk("rst err", 32'(restore_err), 0);
    chk_rf("rst regs_out", rout, Z);

    // first take, sample 0xA one cycle after accept
    tk = 1; rin = '0;
    #1;
    chk("t1 ready", 32'(take_ready), 1);
    chk("t1 id", 32'(take_id), 0);
    edge1();
    chk("t1 done early", 32'(take_done), 0);
    chk("t1 count", 32'(count), 1);
    tk = 0; rin = '0; rin[5] = 32'hA;
    edge1();
    chk("t1 done", 32'(take_done), 1);
    chk("t1 done id", 32'(take_id), 0);
    rin = '0;
    edge1();
    chk("t1 done once", 32'(take_done), 0);
    rs = 1; rid = 0;
    edge1();
    chk("t1 rv", 32'(restore_valid), 1);
    chk("t1 r5", rout[5], 32'hA);
    rs = 0;
    edge1();
    chk("t1 rv pulse", 32'(restore_valid), 0);
    chk("t1 r5 hold", rout[5], 32'hA);

    do_reset();
    //            tk rl rs id v     rdy id dn rv er cnt r5
    tbl[0]  = mk(1, 0, 0, 0, 8'h01, 1, 0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(1, 0, 0, 0, 8'h02, 1, 1, 1, 0, 0, 2, 0);
    tbl[2]  = mk(1, 0, 0, 0, 8'h03, 1, 2, 1, 0, 0, 3, 0);
    tbl[3]  = mk(1, 0, 0, 0, 8'h04, 1, 3, 1, 0, 0, 4, 0);
    tbl[4]  = mk(1, 0, 0, 0, 8'h05, 0, 0, 1, 0, 0, 4, 0);
    tbl[5]  = mk(0, 1, 0, 0, 8'h06, 0, 0, 0, 0, 0, 3, 0);
    tbl[6]  = mk(1, 0, 0, 0, 8'h07, 1, 0, 0, 0, 0, 4, 0);
    tbl[7]  = mk(0, 0, 0, 0, 8'h08, 0, 0, 1, 0, 0, 4, 0);
    tbl[8]  = mk(0, 0, 1, 2, 8'h09, 0, 0, 0, 1, 0, 2, 32'h50004);
    tbl[9]  = mk(0, 0, 1, 3, 8'h09, 0, 0, 0, 0, 1, 2, 32'h50004);
    tbl[10] = mk(1, 0, 0, 0, 8'h0A, 1, 3, 0, 0, 0, 3, 32'h50004);
    tbl[11] = mk(0, 0, 0, 0, 8'h0B, 1, 0, 1, 0, 0, 3, 32'h50004);
    tbl[12] = mk(0, 0, 1, 3, 8'h0C, 0, 0, 0, 1, 0, 3, 32'h5000B);
    tbl[13] = mk(1, 1, 0, 0, 8'h0D, 1, 0, 0, 0, 0, 3, 32'h5000B);
    tbl[14] = mk(0, 0, 0, 0, 8'h0E, 1, 0, 1, 0, 0, 3, 32'h5000B);
    tbl[15] = mk(0, 0, 1, 1, 8'h0F, 0, 0, 0, 0, 1, 3, 32'h5000B);
    tbl[16] = mk(0, 1, 1, 2, 8'h10, 0, 0, 0, 1, 0, 0, 32'h50004);
    tbl[17] = mk(0, 1, 0, 0, 8'h11, 1, 0, 0, 0, 0, 0, 32'h50004);
    tbl[18] = mk(0, 0, 1, 0, 8'h12, 0, 0, 0, 0, 1, 0, 32'h50004);
    tbl[19] = mk(1, 0, 0, 0, 8'h13, 1, 3, 0, 0, 0, 1, 32'h50004);
    tbl[20] = mk(1, 0, 0, 0, 8'h14, 1, 0, 1, 0, 0, 2, 32'h50004);
    tbl[21] = mk(1, 1, 0, 0, 8'h15, 1, 1, 1, 0, 0, 2, 32'h50004);
    tbl[22] = mk(0, 0, 0, 0, 8'h16, 1, 0, 1, 0, 0, 2, 32'h50004);
    tbl[23] = mk(0, 0, 1, 1, 8'h17, 0, 0, 0, 1, 0, 2, 32'h50016);
    tbl[24] = mk(0, 1, 0, 0, 8'h18, 1, 0, 0, 0, 0, 1, 32'h50016);
    tbl[25] = mk(0, 1, 0, 0, 8'h19, 1, 0, 0, 0, 0, 0, 32'h50016);

    for (int i = 0; i < 26; i++) begin
      tk = tbl[i].tk; rl = tbl[i].rl; rs = tbl[i].rs;
      rid = tbl[i].rid; rin = fill(32'(tbl[i].v));
      #1;
      chk($sformatf("row%0d ready", i), 32'(take_ready), 32'(tbl[i].rdy));
      if (tbl[i].tk && tbl[i].rdy)
        chk($sformatf("row%0d id", i), 32'(take_id), 32'(tbl[i].id));
      edge1();
      chk($sformatf("row%0d done", i), 32'(take_done), 32'(tbl[i].dn));
      chk($sformatf("row%0d rv", i), 32'(restore_valid), 32'(tbl[i].rv));
      chk($sformatf("row%0d err", i), 32'(restore_err), 32'(tbl[i].er));
      chk($sformatf("row%0d count", i), 32'(count), tbl[i].cnt);
      chk($sformatf("row%0d full", i), 32'(full), 32'(tbl[i].cnt == 4));
      chk($sformatf("row%0d empty", i), 32'(empty), 32'(tbl[i].cnt == 0));
      chk($sformatf("row%0d r5", i), rout[5], tbl[i].r5);
    end

    // restore of a slot whose capture is still pending
    do_reset();
    tk = 1; rin = Z;
    edge1();
    tk = 0; rs = 1; rid = 0; rin = P;
    #1;
    chk("fwd ready", 32'(take_ready), 0);
    edge1();
    chk("fwd rv", 32'(restore_valid), 1);
    chk("fwd done", 32'(take_done), 1);
    chk_rf("fwd regs_out", rout, P);
    chk("fwd count", 32'(count), 1);
    rs = 0; rin = Z;
    edge1();
    chk("fwd done once", 32'(take_done), 0);
    rs = 1; rid = 0;
    edge1();
    chk_rf("fwd slot kept", rout, P);
    rs = 0;

    // younger pending capture cancelled by restore
    tk = 1; rin = Z;
    #1;
    chk("cx id1", 32'(take_id), 1);
    edge1();
    tk = 1; rin = Q;
    #1;
    chk("cx id2", 32'(take_id), 2);
    edge1();
    chk("cx done1", 32'(take_done), 1);
    chk("cx count3", 32'(count), 3);
    tk = 0; rs = 1; rid = 1; rin = R;
    edge1();
    chk("cx cancel", 32'(take_done), 0);
    chk("cx rv", 32'(restore_valid), 1);
    chk_rf("cx regs_out", rout, Q);
    chk("cx count", 32'(count), 2);
    rs = 0;
    edge1();
    chk("cx no late done", 32'(take_done), 0);

    // reset right after an accepted take
    tk = 1; rin = Z;
    edge1();
    chk("rp count", 32'(count), 3);
    tk = 0; rst = 1; rin = P;
    edge1();
    rst = 0;
    chk("rp done", 32'(take_done), 0);
    chk("rp count0", 32'(count), 0);
    chk("rp empty", 32'(empty), 1);
    chk_rf("rp regs_out", rout, Z);
    edge1();
    chk("rp no done", 32'(take_done), 0);
    chk("rp still empty", 32'(count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
